spm_write_ctrl: RTL and testbench

//  Ingress counterpart of the SPM egress read path. Takes a host write-back stream from the

---
 rtl/spm_write_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_spm_write_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_write_ctrl.sv
// spm_write_ctrl
//   Ingress write-back controller for a private scratchpad bank. It waits for a
//   MAGIC header on the bridge stream, then packs num_words SRAM words from the
//   following beats (first beat in the MSBs) and stores them from address 0 up.
//   On kernel_start the words are read back in order and pushed into the ingress
//   FIFO, each tagged with a wrapping packet ID.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   dbus_in/_valid  bridge beat and its valid; ack is the ready side
//   num_words       word count, sampled while idle
//   load_enable     arms the loader
//   kernel_start    starts the replay once the bank is loaded
//   load_done       level, bank loaded and waiting for kernel_start
//   push_done       one-cycle pulse after the final FIFO push
//   enqueue         ingress FIFO push strobe
//   fifo_full       ingress FIFO full
//   fifo_wdata      {pkt_id, sram_word}
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | sample num_words, clear addresses and pkt_id
// WAIT_MAGIC | accept and drop beats until the MAGIC header
// LOAD       | pack beats into words and write the bank
// LOADED     | bank full, bridge held off, wait for kernel_start
// PUSH       | read the bank through a 2-entry skid buffer into the FIFO
module spm_write_ctrl #(
    parameter int BANK_SIZE      = 512,
    parameter int SRAM_WORD_SIZE = 32,
    parameter int DBUS_WIDTH     = 32,
    parameter int FIFO_WIDTH     = 36,
    parameter int PKT_ID_WIDTH   = 4,
    localparam int AW            = $clog2(BANK_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DBUS_WIDTH-1:0] dbus_in,
    input  logic                  dbus_valid,
    output logic                  ack,
    input  logic [AW-1:0]         num_words,
    input  logic                  load_enable,
    input  logic                  kernel_start,
    output logic                  load_done,
    output logic                  push_done,
    output logic                  enqueue,
    input  logic                  fifo_full,
    output logic [FIFO_WIDTH-1:0] fifo_wdata
);

    localparam int NB = SRAM_WORD_SIZE / DBUS_WIDTH;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [DBUS_WIDTH-1:0] MAGIC = DBUS_WIDTH'(32'hECEBCAFE);

    typedef enum logic [2:0] {IDLE, WAIT_MAGIC, LOAD, LOADED, PUSH} state_t;
    state_t state;

    logic [AW-1:0]             wr_ctr, rd_ctr, wr_addr, rd_addr;
    logic [BW-1:0]             beat_cnt;
    logic [SRAM_WORD_SIZE-1:0] coal;
    logic [SRAM_WORD_SIZE-1:0] mem [BANK_SIZE];
    logic [SRAM_WORD_SIZE-1:0] rdata;
    logic                      rvalid;
    logic [SRAM_WORD_SIZE-1:0] skid0, skid1;
    logic [1:0]                skid_count;
    logic [PKT_ID_WIDTH-1:0]   pkt_id;

    logic                      accept, last_beat, we, ren, last_enq;
    logic [SRAM_WORD_SIZE-1:0] wdata;
    logic [2:0]                occ;

    assign accept    = dbus_valid && ack;
    assign last_beat = (beat_cnt == BW'(NB - 1));
    // Shifting left once per beat leaves the first beat of a word in the MSBs.
    assign wdata     = (coal << DBUS_WIDTH) | SRAM_WORD_SIZE'(dbus_in);
    assign we        = (state == LOAD) && accept && last_beat;

    assign enqueue    = (skid_count != 2'd0) && !fifo_full;
    assign fifo_wdata = {pkt_id, skid0};

    // A slot freed by this cycle's pop counts as free, which is what lets the
    // replay sustain one word per cycle with only two skid entries.
    assign occ      = {1'b0, skid_count} + {2'b00, rvalid} - {2'b00, enqueue};
    assign ren      = (state == PUSH) && (rd_ctr != '0) && (occ < 3'd2);
    assign last_enq = enqueue && (rd_ctr == '0) && !rvalid && (skid_count == 2'd1);

    // Bank storage, deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wdata;
        if (ren)
            rdata <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ack        <= 1'b0;
            load_done  <= 1'b0;
            push_done  <= 1'b0;
            wr_ctr     <= '0;
            rd_ctr     <= '0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            beat_cnt   <= '0;
            coal       <= '0;
            rvalid     <= 1'b0;
            skid0      <= '0;
            skid1      <= '0;
            skid_count <= 2'd0;
            pkt_id     <= '0;
        end else begin
            push_done <= 1'b0;
            rvalid    <= ren;

            unique case ({rvalid, enqueue})
                2'b10: begin
                    if (skid_count == 2'd0)
                        skid0 <= rdata;
                    else
                        skid1 <= rdata;
                    skid_count <= skid_count + 2'd1;
                end
                2'b01: begin
                    skid0      <= skid1;
                    skid_count <= skid_count - 2'd1;
                end
                2'b11: begin
                    if (skid_count == 2'd1) begin
                        skid0 <= rdata;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= rdata;
                    end
                end
                default: ;
            endcase

            if (enqueue)
                pkt_id <= pkt_id + 1'b1;
            if (ren) begin
                rd_addr <= rd_addr + 1'b1;
                rd_ctr  <= rd_ctr - 1'b1;
            end

            unique case (state)
                IDLE: begin
                    wr_ctr   <= num_words;
                    rd_ctr   <= num_words;
                    wr_addr  <= '0;
                    rd_addr  <= '0;
                    beat_cnt <= '0;
                    pkt_id   <= '0;
                    if (load_enable) begin
                        state <= WAIT_MAGIC;
                        ack   <= 1'b1;
                    end
                end
                WAIT_MAGIC: begin
                    if (accept && dbus_in == MAGIC) begin
                        if (wr_ctr == '0) begin
                            state     <= LOADED;
                            ack       <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            wr_addr  <= wr_addr + 1'b1;
                            wr_ctr   <= wr_ctr - 1'b1;
                            if (wr_ctr == AW'(1)) begin
                                state     <= LOADED;
                                ack       <= 1'b0;
                                load_done <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            coal     <= wdata;
                        end
                    end
                end
                LOADED: begin
                    if (kernel_start) begin
                        load_done <= 1'b0;
                        if (rd_ctr == '0) begin
                            push_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= PUSH;
                        end
                    end
                end
                PUSH: begin
                    if (last_enq) begin
                        push_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_write_ctrl.sv
// Testbench for spm_write_ctrl: one 32-bit-word instance and one 64-bit-word
// instance (two beats per word). Expected FIFO traffic is derived from the beat
// stream: skip to the first MAGIC, take the next num_words words, tag k mod 16.
module tb_spm_write_ctrl;

    localparam logic [31:0] MAGIC = 32'hECEBCAFE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // 32-bit word instance
    logic [31:0] dbus_in = '0;
    logic        dbus_valid = 1'b0, ack, load_enable = 1'b0, kernel_start = 1'b0;
    logic [8:0]  num_words = '0;
    logic        load_done, push_done, enqueue, fifo_full = 1'b0;
    logic [35:0] fifo_wdata;

    // 64-bit word instance
    logic [31:0] dbus_in1 = '0;
    logic        dbus_valid1 = 1'b0, ack1, load_enable1 = 1'b0, kernel_start1 = 1'b0;
    logic [3:0]  num_words1 = '0;
    logic        load_done1, push_done1, enqueue1, fifo_full1 = 1'b0;
    logic [67:0] fifo_wdata1;

    spm_write_ctrl #(.BANK_SIZE(512), .SRAM_WORD_SIZE(32), .DBUS_WIDTH(32),
                     .FIFO_WIDTH(36), .PKT_ID_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .dbus_in(dbus_in), .dbus_valid(dbus_valid), .ack(ack),
        .num_words(num_words), .load_enable(load_enable), .kernel_start(kernel_start),
        .load_done(load_done), .push_done(push_done), .enqueue(enqueue),
        .fifo_full(fifo_full), .fifo_wdata(fifo_wdata));

    spm_write_ctrl #(.BANK_SIZE(16), .SRAM_WORD_SIZE(64), .DBUS_WIDTH(32),
                     .FIFO_WIDTH(68), .PKT_ID_WIDTH(4)) dut_nb2 (
        .clk(clk), .rst(rst), .dbus_in(dbus_in1), .dbus_valid(dbus_valid1), .ack(ack1),
        .num_words(num_words1), .load_enable(load_enable1), .kernel_start(kernel_start1),
        .load_done(load_done1), .push_done(push_done1), .enqueue(enqueue1),
        .fifo_full(fifo_full1), .fifo_wdata(fifo_wdata1));

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] beat_q[$];
    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];
    int          enq_cyc_q[$];
    bit          load_to;
    logic        ld_at_accept;
    int          full_viol, stab_viol, pd_cyc, pd_count;

    // Reference: first MAGIC opens the packet, the next nw beats are the words.
    function automatic void build_expect(input int nw);
        int i = 0;
        exp_q.delete();
        while (i < beat_q.size() && beat_q[i] !== MAGIC) i++;
        i++;
        for (int k = 0; k < nw && (i + k) < beat_q.size(); k++)
            exp_q.push_back({k[3:0], beat_q[i + k]});
    endfunction

    function automatic logic [31:0] rand_non_magic();
        logic [31:0] v = $urandom;
        if (v == MAGIC) v = v ^ 32'h1;
        return v;
    endfunction

    // Arms the loader and offers every beat of beat_q until all are accepted.
    task automatic do_load(input int nw, input bit gaps);
        int i = 0;
        int cyc = 0;
        int budget = 4 * beat_q.size() + 50;
        num_words   = 9'(nw);
        load_enable = 1'b1;
        @(posedge clk); #1;
        load_enable  = 1'b0;
        ld_at_accept = 1'bx;
        while (i < beat_q.size() && cyc < budget) begin
            dbus_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            dbus_in    = beat_q[i];
            @(negedge clk);
            if (dbus_valid && ack) begin
                i++;
                ld_at_accept = load_done;
            end
            @(posedge clk); #1;
            cyc++;
        end
        dbus_valid = 1'b0;
        load_to    = (i < beat_q.size());
    endtask

    // Starts the replay and records FIFO traffic; mode 0 never full,
    // 1 toggles every 2 cycles, 2 random.
    task automatic do_push(input int mode, input int n);
        int   cyc = 0;
        bit   prev_hold = 1'b0;
        logic [35:0] prev_wd = '0;
        got_q.delete();
        enq_cyc_q.delete();
        full_viol = 0; stab_viol = 0; pd_cyc = -1; pd_count = 0;
        while (cyc < 400 + 4 * n && !(pd_cyc >= 0 && cyc > pd_cyc + 2)) begin
            kernel_start = (cyc == 0);
            fifo_full = (mode == 0) ? 1'b0 :
                        (mode == 1) ? (((cyc / 2) % 2) == 1) : ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (prev_hold && fifo_wdata !== prev_wd) stab_viol++;
            if (enqueue) begin
                if (fifo_full) full_viol++;
                got_q.push_back(fifo_wdata);
                enq_cyc_q.push_back(cyc);
            end
            if (push_done) begin
                pd_count++;
                if (pd_cyc < 0) pd_cyc = cyc;
            end
            prev_hold = fifo_full && (got_q.size() < exp_q.size()) &&
                        (fifo_wdata === exp_q[got_q.size()]);
            prev_wd = fifo_wdata;
            @(posedge clk); #1;
            cyc++;
        end
        kernel_start = 1'b0;
        fifo_full    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %b want 0", load_done); end
        n_checks++; if (push_done !== 1'b0) begin n_fail++; $display("FAIL reset_push_done: got %b want 0", push_done); end
        n_checks++; if (enqueue !== 1'b0) begin n_fail++; $display("FAIL reset_enqueue: got %b want 0", enqueue); end
        n_checks++; if (ack1 !== 1'b0 || load_done1 !== 1'b0) begin n_fail++; $display("FAIL reset_nb2: ack %b load_done %b want 0 0", ack1, load_done1); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        beat_q = '{MAGIC, 32'h11, 32'h22, 32'h33, 32'h44};
        build_expect(4);
        do_load(4, 1'b0);
        @(negedge clk);
        n_checks++; if (load_to !== 1'b0) begin n_fail++; $display("FAIL basic_load_timeout: got %b want 0", load_to); end
        n_checks++; if (load_done !== 1'b1 || ack !== 1'b0) begin n_fail++; $display("FAIL basic_loaded: load_done %b ack %b want 1 0", load_done, ack); end
        @(posedge clk); #1;
        do_push(0, 4);
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < 4; k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", k, got_q[k], exp_q[k]); end
            n_checks++;
            if (enq_cyc_q[k] != 3 + k) begin n_fail++; $display("FAIL basic_enq_cycle[%0d]: got %0d want %0d", k, enq_cyc_q[k], 3 + k); end
        end
        n_checks++; if (pd_count != 1 || pd_cyc != 7) begin n_fail++; $display("FAIL basic_push_done: count %0d cycle %0d want 1 7", pd_count, pd_cyc); end
    endtask

    task automatic test_junk_magic();
        beat_q = '{32'hDEAD, 32'hBEEF, MAGIC, 32'h5};
        build_expect(1);
        do_load(1, 1'b1);
        n_checks++; if (ld_at_accept !== 1'b0) begin n_fail++; $display("FAIL junk_load_done_early: got %b want 0", ld_at_accept); end
        @(negedge clk);
        n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL junk_load_done: got %b want 1", load_done); end
        @(posedge clk); #1;
        do_push(0, 1);
        n_checks++; if (got_q.size() != 1 || got_q[0] !== 36'h0_0000_0005) begin n_fail++; $display("FAIL junk_data: count %0d first %h want 1 000000005", got_q.size(), (got_q.size() > 0) ? got_q[0] : 36'h0); end
    endtask

    // Loads n words (optionally with junk and embedded MAGIC data), replays
    // under the given backpressure mode and checks the whole transfer.
    task automatic run_transfer(input string name, input int n, input int junk,
                                input bit gaps, input int mode);
        beat_q.delete();
        for (int j = 0; j < junk; j++) beat_q.push_back(rand_non_magic());
        beat_q.push_back(MAGIC);
        for (int j = 0; j < n; j++)
            beat_q.push_back(($urandom_range(0, 15) == 0) ? MAGIC : $urandom);
        build_expect(n);
        do_load(n, gaps);
        n_checks++; if (load_to !== 1'b0) begin n_fail++; $display("FAIL %s_load_timeout: got %b want 0", name, load_to); end
        do_push(mode, n);
        n_checks++; if (got_q.size() != n) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", name, got_q.size(), n); end
        for (int k = 0; k < got_q.size() && k < n; k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL %s_data[%0d]: got %h want %h", name, k, got_q[k], exp_q[k]); end
        end
        n_checks++; if (full_viol != 0) begin n_fail++; $display("FAIL %s_enq_while_full: got %0d want 0", name, full_viol); end
        n_checks++; if (stab_viol != 0) begin n_fail++; $display("FAIL %s_hold_stable: got %0d changes want 0", name, stab_viol); end
        n_checks++;
        if (pd_count != 1 || enq_cyc_q.size() == 0 || pd_cyc != enq_cyc_q[enq_cyc_q.size() - 1] + 1) begin
            n_fail++; $display("FAIL %s_push_done: count %0d cycle %0d want 1 pulse after last enqueue", name, pd_count, pd_cyc);
        end
        @(negedge clk);
        n_checks++; if (load_done !== 1'b0 || ack !== 1'b0) begin n_fail++; $display("FAIL %s_idle_after: load_done %b ack %b want 0 0", name, load_done, ack); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        run_transfer("backpressure", 8, 0, 1'b0, 1);
    endtask

    task automatic test_pkt_wrap();
        run_transfer("pkt_wrap", 20, 2, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++)
            run_transfer("random", $urandom_range(1, 40), $urandom_range(0, 3), 1'b1,
                         $urandom_range(0, 2));
    endtask

    task automatic test_full_bank();
        run_transfer("full_bank", 511, 0, 1'b0, 2);
    endtask

    task automatic test_reset_mid_load();
        beat_q = '{MAGIC, $urandom, $urandom, $urandom};
        do_load(6, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (ack !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL midload_reset: ack %b load_done %b want 0 0", ack, load_done); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ack !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL midload_after: ack %b load_done %b want 0 0", ack, load_done); end
        @(posedge clk); #1;
        run_transfer("rearm", 6, 0, 1'b1, 2);
    endtask

    task automatic test_nb2();
        logic [31:0] bb[5];
        logic [67:0] got[$];
        int i = 0, cyc = 0, pd = 0;
        bb[0] = MAGIC;
        for (int j = 1; j < 5; j++) bb[j] = rand_non_magic();
        num_words1 = 4'd2; load_enable1 = 1'b1;
        @(posedge clk); #1;
        load_enable1 = 1'b0;
        while (i < 5 && cyc < 40) begin
            dbus_valid1 = 1'b1; dbus_in1 = bb[i];
            @(negedge clk);
            if (ack1) i++;
            @(posedge clk); #1;
            cyc++;
        end
        dbus_valid1 = 1'b0;
        @(negedge clk);
        n_checks++; if (load_done1 !== 1'b1 || i != 5) begin n_fail++; $display("FAIL nb2_loaded: load_done %b beats %0d want 1 5", load_done1, i); end
        @(posedge clk); #1;
        for (int c = 0; c < 12; c++) begin
            kernel_start1 = (c == 0);
            @(negedge clk);
            if (enqueue1) got.push_back(fifo_wdata1);
            if (push_done1) pd++;
            @(posedge clk); #1;
        end
        kernel_start1 = 1'b0;
        n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL nb2_count: got %0d want 2", got.size()); end
        n_checks++; if (got.size() > 0 && got[0] !== {4'd0, bb[1], bb[2]}) begin n_fail++; $display("FAIL nb2_word0: got %h want %h", got[0], {4'd0, bb[1], bb[2]}); end
        n_checks++; if (got.size() > 1 && got[1] !== {4'd1, bb[3], bb[4]}) begin n_fail++; $display("FAIL nb2_word1: got %h want %h", got[1], {4'd1, bb[3], bb[4]}); end
        n_checks++; if (pd != 1) begin n_fail++; $display("FAIL nb2_push_done: got %0d pulses want 1", pd); end

        // empty transfer
        num_words1 = 4'd0; load_enable1 = 1'b1;
        @(posedge clk); #1;
        load_enable1 = 1'b0;
        dbus_valid1 = 1'b1; dbus_in1 = MAGIC;
        @(negedge clk);
        n_checks++; if (ack1 !== 1'b1) begin n_fail++; $display("FAIL zero_ack: got %b want 1", ack1); end
        @(posedge clk); #1;
        dbus_valid1 = 1'b0;
        @(negedge clk);
        n_checks++; if (load_done1 !== 1'b1 || ack1 !== 1'b0) begin n_fail++; $display("FAIL zero_loaded: load_done %b ack %b want 1 0", load_done1, ack1); end
        @(posedge clk); #1;
        got.delete(); pd = 0;
        for (int c = 0; c < 8; c++) begin
            kernel_start1 = (c == 0);
            @(negedge clk);
            if (enqueue1) got.push_back(fifo_wdata1);
            if (push_done1) pd++;
            @(posedge clk); #1;
        end
        kernel_start1 = 1'b0;
        n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL zero_enqueue: got %0d want 0", got.size()); end
        n_checks++; if (pd != 1) begin n_fail++; $display("FAIL zero_push_done: got %0d pulses want 1", pd); end
        n_checks++; if (load_done1 !== 1'b0) begin n_fail++; $display("FAIL zero_idle: load_done %b want 0", load_done1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_junk_magic();
        test_backpressure();
        test_pkt_wrap();
        test_back_to_back();
        test_full_bank();
        test_reset_mid_load();
        test_nb2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
